// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tristate data bus with hold-time limit
// and a mandatory idle turnaround between consecutive grants.
module bus_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_HOLD  = 8,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         data_enable_low,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     bus_busy
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int unsigned TA_W   = $clog2(TA_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURNAROUND
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  den_q, den_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TA_W-1:0]   ta_cnt_q, ta_cnt_d;
  logic              busy_q, busy_d;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              win_valid;
  logic              start_grant;

  // Scan starts just past the last owner, so a timed-out owner still
  // requesting is considered last.
  always_comb begin
    winner    = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(last_owner_q) + i) % N_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    ta_cnt_d     = ta_cnt_q;
    busy_d       = busy_q;
    start_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) start_grant = 1'b1;
      end
      GRANT: begin
        if (!req[grant_id_q] || hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
          state_d    = TURNAROUND;
          gnt_d      = '0;
          hold_cnt_d = '0;
          ta_cnt_d   = TA_W'(1);
          busy_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      TURNAROUND: begin
        if (ta_cnt_q == TA_W'(TA_CYCLES)) begin
          ta_cnt_d = '0;
          if (win_valid) begin
            start_grant = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ta_cnt_d = ta_cnt_q + TA_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (start_grant) begin
      state_d      = GRANT;
      gnt_d        = N_REQ'(1) << winner;
      grant_id_d   = winner;
      last_owner_d = winner;
      hold_cnt_d   = HOLD_W'(1);
      busy_d       = 1'b1;
    end

    den_d = ~gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      den_q        <= '1;
      grant_id_q   <= '0;
      last_owner_q <= ID_W'(N_REQ - 1);
      hold_cnt_q   <= '0;
      ta_cnt_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      den_q        <= den_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      ta_cnt_q     <= ta_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt             = gnt_q;
  assign data_enable_low = den_q;
  assign grant_id        = grant_id_q;
  assign bus_busy        = busy_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_den_inverse: assert property (@(posedge clk) disable iff (rst) den_q == ~gnt_q);
  a_gnt_state:   assert property (@(posedge clk) disable iff (rst)
                                  (state_q == GRANT) == (gnt_q != '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// requests compared against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int TA = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [N-1:0] del;
  logic [1:0]   gid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: who owns the bus, how long, and remaining idle gap
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_last  = N - 1;
  int m_id    = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TA_CYCLES(TA)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .data_enable_low(del), .grant_id(gid), .bus_busy(busy)
  );

  function automatic int rr_pick(logic [N-1:0] r, int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  function automatic void model_step();
    int w;
    if (rst) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_id = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MH) begin
        m_owner = -1;
        m_gap   = TA;
      end else begin
        m_held++;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0) begin
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_owner = w; m_held = 1; m_last = w; m_id = w;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    tick();
    tick();
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_tests++;
    if (del !== 4'b1111) begin n_fail++; $display("FAIL reset_den: got %b expected 1111", del); end
    n_tests++;
    if (gid !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", gid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 4'b0001;
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL first_latency: got %b expected 0000", gnt); end
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL first_gnt: got %b expected 0001", gnt); end
    n_tests++;
    if (del !== 4'b1110) begin n_fail++; $display("FAIL first_den: got %b expected 1110", del); end
    n_tests++;
    if (gid !== 2'd0) begin n_fail++; $display("FAIL first_id: got %0d expected 0", gid); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b expected 1", busy); end
  endtask

  task automatic test_round_robin();
    int pos, idx;
    logic [N-1:0] e;
    do_reset();
    req = 4'b1111;
    for (int k = 1; k <= 5 * (MH + TA); k++) begin
      tick();
      pos = (k - 1) % (MH + TA);
      idx = ((k - 1) / (MH + TA)) % N;
      e = '0;
      if (pos < MH) e[idx] = 1'b1;
      n_tests++;
      if (gnt !== e) begin n_fail++; $display("FAIL rr_gnt cyc %0d: got %b expected %b", k, gnt, e); end
      n_tests++;
      if (del !== ~e) begin n_fail++; $display("FAIL rr_den cyc %0d: got %b expected %b", k, del, ~e); end
      n_tests++;
      if (gid !== 2'(idx)) begin n_fail++; $display("FAIL rr_id cyc %0d: got %0d expected %0d", k, gid, idx); end
    end
  endtask

  task automatic test_early_release();
    logic [N-1:0] rq [5];
    logic [N-1:0] ex [5];
    rq = '{4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0001};
    ex = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = rq[i];
      tick();
      n_tests++;
      if (gnt !== ex[i]) begin n_fail++; $display("FAIL early_rel step %0d: got %b expected %b", i, gnt, ex[i]); end
    end
  endtask

  task automatic test_single_hold();
    logic [N-1:0] e;
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= 2 * (MH + TA) + 2; k++) begin
      tick();
      e = (((k - 1) % (MH + TA)) < MH) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (gnt !== e) begin n_fail++; $display("FAIL hold_gnt cyc %0d: got %b expected %b", k, gnt, e); end
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy cyc %0d: got %b expected 1", k, busy); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    n_tests++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_own3: got %b expected 1000", gnt); end
    req = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt: got %b expected 0000", gnt); end
    n_tests++;
    if (del !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_den: got %b expected 1111", del); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_tests++;
    if (gid !== 2'd0) begin n_fail++; $display("FAIL mid_rst_id: got %0d expected 0", gid); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_next_own: got %b expected 0001", gnt); end
    // now reset during a turnaround cycle
    req = 4'b0000;
    tick();
    n_tests++;
    if (busy !== 1'b1 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL ta_entry: got busy=%b gnt=%b expected busy=1 gnt=0000", busy, gnt);
    end
    rst = 1'b1;
    req = 4'b0010;
    tick();
    n_tests++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL ta_rst: got busy=%b gnt=%b expected busy=0 gnt=0000", busy, gnt);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ta_rst_next: got %b expected 0010", gnt); end
  endtask

  task automatic test_random();
    logic [N-1:0] e, prev_g;
    int run, gap;
    bit seen;
    do_reset();
    prev_g = '0; run = 0; gap = 0; seen = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      rst = ($urandom_range(0, 499) == 0);
      tick();
      e = exp_gnt();
      n_tests++;
      if (gnt !== e) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", c, gnt, e); end
      n_tests++;
      if (del !== ~e) begin n_fail++; $display("FAIL rnd_den cyc %0d: got %b expected %b", c, del, ~e); end
      n_tests++;
      if (gid !== 2'(m_id)) begin n_fail++; $display("FAIL rnd_id cyc %0d: got %0d expected %0d", c, gid, m_id); end
      n_tests++;
      if (busy !== ((m_owner >= 0) || (m_gap > 0))) begin
        n_fail++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", c, busy, (m_owner >= 0) || (m_gap > 0));
      end
      n_tests++;
      if ($countones(~del) > 1) begin n_fail++; $display("FAIL rnd_enables cyc %0d: got %b expected at most one low", c, del); end
      if (gnt != '0) begin
        if (gnt == prev_g) begin
          run++;
        end else begin
          n_tests++;
          if (prev_g != '0) begin
            n_fail++; $display("FAIL rnd_direct cyc %0d: got %b after %b expected a gap", c, gnt, prev_g);
          end
          n_tests++;
          if (seen && gap < TA) begin
            n_fail++; $display("FAIL rnd_gap cyc %0d: got %0d idle cycles expected >= %0d", c, gap, TA);
          end
          run = 1; gap = 0; seen = 1'b1;
        end
        n_tests++;
        if (run > MH) begin n_fail++; $display("FAIL rnd_hold cyc %0d: got %0d cycles expected <= %0d", c, run, MH); end
      end else begin
        gap++;
      end
      prev_g = gnt;
      if (rst) begin seen = 1'b0; gap = 0; run = 0; end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_first_grant();
    test_round_robin();
    test_early_release();
    test_single_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the tristate data bus (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 8, max consecutive cycles one grant may be held (1..255).
REQ-003 SHALL have parameter TA_CYCLES, default 1, bus-idle turnaround cycles between grants (1..4).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester bus request, level; held high while requester wants the bus.
REQ-007 gnt  output  N_REQ  one-hot grant, registered; all-zero when no owner.
REQ-008 data_enable_low  output  N_REQ  active-low tristate driver enables, registered; bit i low only when gnt[i] high.
REQ-009 grant_id  output  clog2(N_REQ)  index of current owner; holds last owner when idle.
REQ-010 bus_busy  output  1  high in GRANT and TURNAROUND states.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, TURNAROUND.
REQ-012 IDLE: if req != 0 at a rising edge, select winner and enter GRANT; gnt[winner] high starting the next cycle (1-cycle latency); else stay IDLE.
REQ-013 Winner selection SHALL be round-robin: search from (last_owner+1) mod N_REQ upward with wrap, first set req bit wins.
REQ-014 GRANT: hold_cnt increments each cycle from 1; leave GRANT when req[owner] sampled low or hold_cnt == MAX_HOLD, whichever first.
REQ-015 Owner SHALL hold gnt for exactly MAX_HOLD cycles when req stays high; minimum 1 cycle.
REQ-016 Leaving GRANT SHALL enter TURNAROUND: gnt all-zero, data_enable_low all-ones (bus undriven, Z) for exactly TA_CYCLES cycles.
REQ-017 At end of TURNAROUND: if req != 0, arbitrate per REQ-013 and enter GRANT directly; else enter IDLE.
REQ-018 last_owner SHALL update on entry to GRANT; timed-out owner with req still high is lowest priority next round.
REQ-019 At most one bit of data_enable_low SHALL be low in any cycle; data_enable_low == ~gnt at all times.
REQ-020 No direct GRANT->GRANT transition; every owner change passes through TURNAROUND.
REQ-021 req changes of non-owners during GRANT SHALL not affect current grant.
REQ-022 Single requester with continuous req: pattern MAX_HOLD grant cycles, TA_CYCLES idle, repeat.
REQ-023 grant_id SHALL update same cycle gnt asserts.

Reset
REQ-024 rst high at rising edge: state IDLE, gnt=0, data_enable_low all-ones, grant_id=0, bus_busy=0, hold_cnt=0, last_owner=N_REQ-1 (requester 0 first priority).
REQ-025 rst mid-GRANT or mid-TURNAROUND SHALL release bus next cycle with no turnaround, reset values per REQ-024.
REQ-026 After rst drops, first grant no earlier than 1 cycle after req sampled.

Verification
REQ-027 Reset then req=4'b0001 at cycle 0 -> gnt=0001, data_enable_low=1110, grant_id=0 from cycle 1.
REQ-028 req=4'b1111 held, defaults -> owners 0,1,2,3,0 each 8 cycles of gnt, separated by 1 cycle with data_enable_low=1111.
REQ-029 Owner 2 drops req after 3 grant cycles while req[0]=1 -> gnt=0100 for 3 cycles, 1 turnaround cycle, then gnt=0001.
REQ-030 req=4'b0010 held alone, MAX_HOLD=8 -> gnt=0010 8 cycles, 0000 1 cycle, 0010 again; bus_busy stays 1.
REQ-031 rst pulsed during grant to owner 3 -> next cycle gnt=0000, data_enable_low=1111, bus_busy=0; with req=1111 next owner is 0.
REQ-032 Random req, N_REQ=4, 10000 cycles -> checker: never >1 enable low, every owner change has TA_CYCLES all-high gap, no grant >MAX_HOLD.
